// File: rtl/upsp_dispatch_ctrl.sv
// Frame scheduler: routes AXI-Stream pixels to N_PARALLEL up-sampling PEs with overlap multicast.
// Optional stall counter enabled by defining UPSP_DISPATCH_PERF_EN.
module upsp_dispatch_ctrl #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int SRC_IMG_WIDTH  = 1920,
  parameter  int SRC_IMG_HEIGHT = 1080,
  parameter  int N_PARALLEL     = 2,
  parameter  int OVERLAP        = 2,
  localparam int COL_W          = $clog2(SRC_IMG_WIDTH),
  localparam int ROW_W          = $clog2(SRC_IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic [N_PARALLEL-1:0] pe_valid,
  input  logic [N_PARALLEL-1:0] pe_ready,
  output logic [DATA_WIDTH-1:0] pe_data,
  input  logic [N_PARALLEL-1:0] pe_done,
  output logic [COL_W-1:0]      col_out,
  output logic [ROW_W-1:0]      row_out,
  output logic [31:0]           perf_stall_cnt
);

  localparam int BLK = SRC_IMG_WIDTH / N_PARALLEL;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_WAIT_PE = 2'd3;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_IMG_HEIGHT - 1);

  function automatic int blk_lo(input int k);
    return (k * BLK > OVERLAP) ? (k * BLK - OVERLAP) : 0;
  endfunction

  function automatic int blk_hi(input int k);
    return ((k + 1) * BLK - 1 + OVERLAP < SRC_IMG_WIDTH) ? ((k + 1) * BLK - 1 + OVERLAP)
                                                         : (SRC_IMG_WIDTH - 1);
  endfunction

  logic [1:0]            state_q,   state_d;
  logic [N_PARALLEL-1:0] pending_q, pending_d;
  logic [DATA_WIDTH-1:0] pe_data_q, pe_data_d;
  logic [COL_W-1:0]      col_q,     col_d;
  logic [ROW_W-1:0]      row_q,     row_d;
  logic                  err_q,     err_d;
  logic [N_PARALLEL-1:0] done_q,    done_d;

  logic [N_PARALLEL-1:0] target_mask_s;
  logic                  s_tready_s;
  logic                  accept_s;
  logic                  col_last_s;
  logic                  last_px_s;

  // Target PE mask for the column about to be accepted.
  always_comb begin
    target_mask_s = '0;
    for (int k = 0; k < N_PARALLEL; k++) begin
      target_mask_s[k] = (int'(col_q) >= blk_lo(k)) && (int'(col_q) <= blk_hi(k));
    end
  end

  // A new pixel fits once every pending PE either is idle or takes it this cycle.
  assign s_tready_s = (state_q == ST_RUN) && ((pending_q & ~pe_ready) == '0);
  assign accept_s   = s_tvalid && s_tready_s;
  assign col_last_s = (col_q == COL_LAST);
  assign last_px_s  = col_last_s && (row_q == ROW_LAST);

  // Next-state for FSM, hold stage, position counters and sticky flags.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q & ~pe_ready;
    pe_data_d = pe_data_q;
    col_d     = col_q;
    row_d     = row_q;
    err_d     = err_q;
    done_d    = done_q;

    if (accept_s) begin
      pe_data_d = s_tdata;
      pending_d = target_mask_s;
      if (col_last_s) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? row_q : (row_q + ROW_W'(1));
      end else begin
        col_d = col_q + COL_W'(1);
        row_d = row_q;
      end
      if (s_tlast != col_last_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      pe_data_d = pe_data_q;
    end

    if (state_q != ST_IDLE) begin
      done_d = done_q | pe_done;
    end else begin
      done_d = done_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          done_d  = '0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_px_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pending_q == '0) begin
          state_d = ST_WAIT_PE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_WAIT_PE: begin
        if (&done_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_PE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any pending pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      pe_data_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pe_data_q <= pe_data_d;
      col_q     <= col_d;
      row_q     <= row_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

`ifdef UPSP_DISPATCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where input is offered but refused in RUN.
  always_comb begin
    if ((state_q == ST_IDLE) && start) begin
      stall_d = 32'd0;
    end else if ((state_q == ST_RUN) && s_tvalid && !s_tready_s && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_WAIT_PE) && (&done_q);
  assign err_tlast  = err_q;
  assign s_tready   = s_tready_s;
  assign pe_valid   = pending_q;
  assign pe_data    = pe_data_q;
  assign col_out    = col_q;
  assign row_out    = row_q;

endmodule
